// File: rtl/matriz_pkg.sv
// Shared types and constants for the matrix ALU sequencer.
// State encoding, opcode set and the operand-B predicate.
package matriz_pkg;

  localparam int N_ELEM      = 25;
  localparam int ELEM_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int BUS_W       = N_ELEM * ELEM_W;
  localparam int IDX_W       = 5;
  localparam int ALU_TIMEOUT = 1024;
  localparam int TO_W        = $clog2(ALU_TIMEOUT);

  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_MUL = 4'b0101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    DRAIN,
    EXEC,
    STORE,
    FINISH
  } state_t;

  function automatic logic needs_b(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/matriz_if.sv
// Instruction, data-memory and ALU signals of the sequencer.
// master = sequencer side, slave = environment side.
interface matriz_if;
  import matriz_pkg::*;

  logic              instr_valid;
  logic              instr_ready;
  logic [3:0]        instr_opcode;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic [ADDR_W-1:0] base_r;

  logic              mem_rd_en;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic [ELEM_W-1:0] mem_rdata;

  logic [3:0]        alu_opcode;
  logic [BUS_W-1:0]  matrizA;
  logic [BUS_W-1:0]  matrizB;
  logic              alu_start;
  logic              alu_done;
  logic [BUS_W-1:0]  matriz_resultante;

  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  instr_valid, instr_opcode, base_a, base_b, base_r,
    input  mem_rdata, alu_done, matriz_resultante,
    output instr_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    output alu_opcode, matrizA, matrizB, alu_start,
    output busy, done, error
  );

  modport slave (
    output instr_valid, instr_opcode, base_a, base_b, base_r,
    output mem_rdata, alu_done, matriz_resultante,
    input  instr_ready, mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
    input  alu_opcode, matrizA, matrizB, alu_start,
    input  busy, done, error
  );

endinterface

// File: rtl/matriz_byte_packer.sv
// Byte-addressed write port into a packed 5x5 matrix register.
// Element i lives at [8i+7:8i]; clr zeroes the whole matrix.
module matriz_byte_packer
  import matriz_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [ELEM_W-1:0] din,
  output logic [BUS_W-1:0]  q
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      q <= '0;
    end else if (we) begin
      q[int'(idx)*ELEM_W +: ELEM_W] <= din;
    end
  end

endmodule

// File: rtl/matriz_controlador.sv
// Sequencer: load A/B from memory, run the ALU handshake,
// store the 25 result bytes, then pulse done.
module matriz_controlador
  import matriz_pkg::*;
(
  input logic      clk,
  input logic      reset,
  matriz_if.master bus
);

  state_t            state, state_n;
  logic [IDX_W-1:0]  cnt, pidx;
  logic [TO_W-1:0]   tcnt;
  logic [3:0]        op;
  logic [ADDR_W-1:0] ba, bb, br;
  logic [BUS_W-1:0]  res, a_q, b_q;
  logic              pend_a, pend_b, err;
  logic              last, tmo, accept, clr_b;

  assign last   = cnt == IDX_W'(N_ELEM - 1);
  assign tmo    = tcnt == TO_W'(ALU_TIMEOUT - 1);
  assign accept = (state == IDLE) && bus.instr_valid;
  assign clr_b  = (state == LOAD_A) && last && !needs_b(op);

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:   if (bus.instr_valid) state_n = LOAD_A;
      LOAD_A: if (last) state_n = needs_b(op) ? LOAD_B : DRAIN;
      LOAD_B: if (last) state_n = DRAIN;
      DRAIN:  state_n = EXEC;
      EXEC: begin
        if (bus.alu_done) state_n = STORE;
        else if (tmo)     state_n = FINISH;
      end
      STORE:  if (last) state_n = FINISH;
      FINISH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      tcnt   <= '0;
      pidx   <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      op     <= '0;
      ba     <= '0;
      bb     <= '0;
      br     <= '0;
      res    <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      pend_a <= state == LOAD_A;
      pend_b <= state == LOAD_B;
      pidx   <= cnt;
      if (state != state_n) cnt <= '0;
      else cnt <= cnt + 1'b1;
      if (state == EXEC) tcnt <= tcnt + 1'b1;
      else tcnt <= '0;
      if (accept) begin
        op  <= bus.instr_opcode;
        ba  <= bus.base_a;
        bb  <= bus.base_b;
        br  <= bus.base_r;
        err <= 1'b0;
      end
      if (state == EXEC && bus.alu_done)
        res <= bus.matriz_resultante;
      else if (state == EXEC && tmo)
        err <= 1'b1;
    end
  end

  // Read data lags the strobe by one cycle, so capture uses pidx.
  matriz_byte_packer u_pack_a (
    .clk   (clk),
    .reset (reset),
    .clr   (accept),
    .we    (pend_a),
    .idx   (pidx),
    .din   (bus.mem_rdata),
    .q     (a_q)
  );

  matriz_byte_packer u_pack_b (
    .clk   (clk),
    .reset (reset),
    .clr   (clr_b),
    .we    (pend_b),
    .idx   (pidx),
    .din   (bus.mem_rdata),
    .q     (b_q)
  );

  always_comb begin
    bus.instr_ready = state == IDLE;
    bus.busy        = state != IDLE;
    bus.done        = state == FINISH;
    bus.alu_start   = state == EXEC;
    bus.mem_rd_en   = (state == LOAD_A) || (state == LOAD_B);
    bus.mem_wr_en   = state == STORE;
    bus.mem_wdata   = '0;
    bus.mem_addr    = '0;
    bus.alu_opcode  = op;
    bus.matrizA     = a_q;
    bus.matrizB     = b_q;
    bus.error       = err;
    unique case (1'b1)
      state == LOAD_A: bus.mem_addr = ba + ADDR_W'(cnt);
      state == LOAD_B: bus.mem_addr = bb + ADDR_W'(cnt);
      state == STORE: begin
        bus.mem_addr  = br + ADDR_W'(cnt);
        bus.mem_wdata = res[int'(cnt)*ELEM_W +: ELEM_W];
      end
      default: bus.mem_addr = '0;
    endcase
  end

endmodule
